// File: rtl/ethrxfilter_pkg.sv
// ethrxfilter_pkg: shared states, defaults and destination
// classification for the receive-side frame filter.
package ethrxfilter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_READ    = 3'd2,
    S_MATCH   = 3'd3,
    S_PRESENT = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  typedef logic [3:0] stat_t;

  localparam int DEF_MIN_LEN = 60;
  localparam int DEF_MAX_LEN = 1514;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam int STAT_UNI = 0;
  localparam int STAT_BC  = 1;
  localparam int STAT_MC  = 2;
  localparam int STAT_PRO = 3;

  // One-hot class of a destination; all-zero means reject.
  function automatic stat_t classify(
    input logic [47:0] d,
    input logic [47:0] me,
    input logic        pro,
    input logic        am
  );
    stat_t s;
    s = '0;
    if (d == BCAST_MAC)
      s[STAT_BC] = 1'b1;
    else if (d[40] && (am || pro))
      s[STAT_MC] = 1'b1;
    else if (d == me)
      s[STAT_UNI] = 1'b1;
    else if (pro)
      s[STAT_PRO] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ethrxfilter_satcnt16.sv
// satcnt16: 16-bit saturating event counter,
// synchronous clear wins over increment.
module satcnt16
  import ethrxfilter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ethrxfilter.sv
// ethrxfilter: checks, address-filters and presents received
// frames to the host, then hands the buffer back to the receiver.
module ethrxfilter
  import ethrxfilter_pkg::*;
#(
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        rxrdy,
  input  logic [10:0] rxcntb,
  input  logic        err_gen,
  input  logic        err_crc,
  output logic        rxdone,
  output logic [9:0]  bufaddr,
  output logic        bufrd,
  input  logic [15:0] bufdata,
  input  logic [47:0] mymac,
  input  logic        promisc,
  input  logic        allmulti,
  output logic        frmrdy,
  output logic [10:0] frmlen,
  output logic [3:0]  frmstat,
  input  logic        frmack,
  input  logic        cnt_clr,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err,
  output logic [15:0] cnt_flt
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_e      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic [47:0] dst_q, dst_d;
  logic [9:0]  bufaddr_q, bufaddr_d;
  logic        bufrd_q, bufrd_d;
  logic        rxdone_q, rxdone_d;
  logic        frmrdy_q, frmrdy_d;
  logic [10:0] frmlen_q, frmlen_d;
  stat_t       frmstat_q, frmstat_d;
  stat_t       stat;
  logic        len_bad;
  logic        inc_ok, inc_err, inc_flt;

  assign len_bad = (len_q < MIN_L) || (len_q > MAX_L);
  assign stat    = classify(dst_q, mymac, promisc, allmulti);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    err_d     = err_q;
    rd_cnt_d  = rd_cnt_q;
    dst_d     = dst_q;
    bufaddr_d = bufaddr_q;
    bufrd_d   = bufrd_q;
    rxdone_d  = rxdone_q;
    frmrdy_d  = frmrdy_q;
    frmlen_d  = frmlen_q;
    frmstat_d = frmstat_q;
    inc_ok    = 1'b0;
    inc_err   = 1'b0;
    inc_flt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rxdone_d = 1'b0;
        bufrd_d  = 1'b0;
        if (rxrdy) begin
          len_d   = rxcntb;
          err_d   = {err_gen, err_crc};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (|err_q) begin
          inc_err  = 1'b1;
          rxdone_d = 1'b1;
          state_d  = S_RELEASE;
        end else if (len_bad) begin
          inc_flt  = 1'b1;
          rxdone_d = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          bufaddr_d = '0;
          bufrd_d   = 1'b1;
          rd_cnt_d  = '0;
          state_d   = S_READ;
        end
      end
      // Capture lags issue by one cycle: word n lands at count n+1.
      S_READ: begin
        rd_cnt_d = rd_cnt_q + 2'd1;
        unique case (rd_cnt_q)
          2'd0: bufaddr_d = 10'd1;
          2'd1: begin
            bufaddr_d     = 10'd2;
            dst_d[47:32]  = bufdata;
          end
          2'd2: begin
            bufrd_d      = 1'b0;
            dst_d[31:16] = bufdata;
          end
          default: begin
            dst_d[15:0] = bufdata;
            state_d     = S_MATCH;
          end
        endcase
      end
      S_MATCH: begin
        if (stat == '0) begin
          inc_flt  = 1'b1;
          rxdone_d = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          frmlen_d  = len_q;
          frmstat_d = stat;
          frmrdy_d  = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (frmack) begin
          frmrdy_d = 1'b0;
          inc_ok   = 1'b1;
          rxdone_d = 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        rxdone_d = 1'b1;
        if (!rxrdy) begin
          rxdone_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      err_q     <= '0;
      rd_cnt_q  <= '0;
      dst_q     <= '0;
      bufaddr_q <= '0;
      bufrd_q   <= 1'b0;
      rxdone_q  <= 1'b0;
      frmrdy_q  <= 1'b0;
      frmlen_q  <= '0;
      frmstat_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      err_q     <= err_d;
      rd_cnt_q  <= rd_cnt_d;
      dst_q     <= dst_d;
      bufaddr_q <= bufaddr_d;
      bufrd_q   <= bufrd_d;
      rxdone_q  <= rxdone_d;
      frmrdy_q  <= frmrdy_d;
      frmlen_q  <= frmlen_d;
      frmstat_q <= frmstat_d;
    end
  end

  assign rxdone  = rxdone_q;
  assign bufaddr = bufaddr_q;
  assign bufrd   = bufrd_q;
  assign frmrdy  = frmrdy_q;
  assign frmlen  = frmlen_q;
  assign frmstat = frmstat_q;

  satcnt16 u_cnt_ok (
    .clk   (clk),
    .rst_n (clr_n),
    .clr   (cnt_clr),
    .inc   (inc_ok),
    .cnt   (cnt_ok)
  );

  satcnt16 u_cnt_err (
    .clk   (clk),
    .rst_n (clr_n),
    .clr   (cnt_clr),
    .inc   (inc_err),
    .cnt   (cnt_err)
  );

  satcnt16 u_cnt_flt (
    .clk   (clk),
    .rst_n (clr_n),
    .clr   (cnt_clr),
    .inc   (inc_flt),
    .cnt   (cnt_flt)
  );

endmodule

// File: tb/tb_ethrxfilter.sv
// tb_ethrxfilter: directed frames with a scoreboard of expected
// presentations, plus a standalone saturation run of satcnt16.
module tb_ethrxfilter;
  import ethrxfilter_pkg::*;

  localparam logic [47:0] MY  = 48'h0011_2233_4455;
  localparam logic [47:0] FGN = 48'h0011_2233_4466;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MC  = 48'h0100_5E00_0001;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        rxrdy = 1'b0;
  logic [10:0] rxcntb = '0;
  logic        err_gen = 1'b0;
  logic        err_crc = 1'b0;
  logic        rxdone;
  logic [9:0]  bufaddr;
  logic        bufrd;
  logic [15:0] bufdata = '0;
  logic [47:0] mymac = MY;
  logic        promisc = 1'b0;
  logic        allmulti = 1'b0;
  logic        frmrdy;
  logic [10:0] frmlen;
  logic [3:0]  frmstat;
  logic        frmack = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_ok, cnt_err, cnt_flt;

  logic        s_rst_n = 1'b1;
  logic        s_clr = 1'b0;
  logic        s_inc = 1'b0;
  logic [15:0] s_cnt;

  int tests = 0;
  int fails = 0;
  int exp_ok = 0;
  int exp_err = 0;
  int exp_flt = 0;

  logic [14:0] sb_q[$];
  logic [14:0] cur = '0;
  logic        rdy_prev = 1'b0;
  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bufrd) bufdata <= mem[bufaddr];

  ethrxfilter dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .rxrdy    (rxrdy),
    .rxcntb   (rxcntb),
    .err_gen  (err_gen),
    .err_crc  (err_crc),
    .rxdone   (rxdone),
    .bufaddr  (bufaddr),
    .bufrd    (bufrd),
    .bufdata  (bufdata),
    .mymac    (mymac),
    .promisc  (promisc),
    .allmulti (allmulti),
    .frmrdy   (frmrdy),
    .frmlen   (frmlen),
    .frmstat  (frmstat),
    .frmack   (frmack),
    .cnt_clr  (cnt_clr),
    .cnt_ok   (cnt_ok),
    .cnt_err  (cnt_err),
    .cnt_flt  (cnt_flt)
  );

  satcnt16 u_sat (
    .clk   (clk),
    .rst_n (s_rst_n),
    .clr   (s_clr),
    .inc   (s_inc),
    .cnt   (s_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: each rising frmrdy pops one expected {len, stat}.
  always @(negedge clk) begin
    if (frmrdy && !rdy_prev) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frmrdy: got len %0d stat %b, required none",
                 frmlen, frmstat);
      end else begin
        cur = sb_q.pop_front();
        chk("present", {17'd0, frmlen, frmstat}, {17'd0, cur});
      end
    end else if (frmrdy) begin
      chk("hold", {17'd0, frmlen, frmstat}, {17'd0, cur});
    end
    rdy_prev <= frmrdy;
  end

  task automatic chk_cnts(input string nm);
    chk({nm, " cnt_ok"},  {16'd0, cnt_ok},  exp_ok);
    chk({nm, " cnt_err"}, {16'd0, cnt_err}, exp_err);
    chk({nm, " cnt_flt"}, {16'd0, cnt_flt}, exp_flt);
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    exp_flt = 0;
  endtask

  task automatic finish_frame(input int ackd, input logic clra,
                              input string nm);
    if (frmrdy) begin
      @(negedge clk);
      repeat (ackd) @(negedge clk);
      frmack  = 1'b1;
      cnt_clr = clra;
      @(negedge clk);
      frmack  = 1'b0;
      cnt_clr = 1'b0;
      chk({nm, " frmrdy_drop"}, frmrdy, 0);
    end else begin
      @(negedge clk);
    end
    chk({nm, " rxdone_hi"}, rxdone, 1);
    rxrdy = 1'b0;
    @(posedge clk);
    #1 chk({nm, " rxdone_lo"}, rxdone, 0);
  endtask

  task automatic run_frame(input logic [47:0] d, input logic [10:0] len,
                           input logic ge, input logic ce,
                           input logic acc, input logic [3:0] st,
                           input int eedge, input int ackd,
                           input logic clra, input string nm);
    int   k;
    logic seen;
    mem[0] = d[47:32];
    mem[1] = d[31:16];
    mem[2] = d[15:0];
    if (acc) sb_q.push_back({len, st});
    @(negedge clk);
    rxrdy   = 1'b1;
    rxcntb  = len;
    err_gen = ge;
    err_crc = ce;
    k    = -1;
    seen = 1'b0;
    while (k < 20 && !frmrdy && !rxdone) begin
      @(posedge clk);
      #1 k++;
      if (bufrd) seen = 1'b1;
    end
    chk({nm, " edge"}, k, eedge);
    chk({nm, " path"}, acc ? frmrdy : rxdone, 1);
    chk({nm, " bufrd"}, seen, (eedge == 1) ? 0 : 1);
    finish_frame(ackd, clra, nm);
    err_gen = 1'b0;
    err_crc = 1'b0;
    if (clra) begin
      exp_ok = 0;
      exp_err = 0;
      exp_flt = 0;
    end else if (acc) exp_ok++;
    else if (ge || ce) exp_err++;
    else exp_flt++;
    chk_cnts(nm);
  endtask

  task automatic reset_test();
    int k;
    mem[0] = MY[47:32];
    mem[1] = MY[31:16];
    mem[2] = MY[15:0];
    sb_q.push_back({11'd200, 4'b0001});
    @(negedge clk);
    rxrdy  = 1'b1;
    rxcntb = 11'd200;
    k = 0;
    while (k < 20 && !frmrdy) begin
      @(posedge clk);
      #1 k++;
    end
    chk("rst pre frmrdy", frmrdy, 1);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("rst frmrdy", frmrdy, 0);
    chk("rst frmstat", frmstat, 0);
    chk("rst bufaddr", bufaddr, 0);
    exp_ok = 0;
    exp_err = 0;
    exp_flt = 0;
    chk_cnts("rst");
    sb_q.push_back({11'd200, 4'b0001});
    @(negedge clk);
    #2 clr_n = 1'b1;
    k = -1;
    while (k < 20 && !frmrdy) begin
      @(posedge clk);
      #1 k++;
    end
    chk("rst re-present edge", k, 6);
    finish_frame(1, 1'b0, "rst");
    exp_ok++;
    chk_cnts("rst post");
  endtask

  task automatic main_seq();
    run_frame(MY, 11'd100, 0, 0, 1, 4'b0001, 6, 2, 0, "uni");
    run_frame(BC, 11'd64, 0, 0, 1, 4'b0010, 6, 1, 0, "bcast");
    allmulti = 1'b1;
    run_frame(MC, 11'd128, 0, 0, 1, 4'b0100, 6, 0, 0, "mcast_am");
    allmulti = 1'b0;
    clear_cnt();
    run_frame(MC, 11'd100, 0, 0, 0, 4'b0000, 6, 0, 0, "mcast_rej");
    clear_cnt();
    run_frame(MY, 11'd100, 0, 1, 0, 4'b0000, 1, 0, 0, "err_crc");
    run_frame(MY, 11'd100, 1, 0, 0, 4'b0000, 1, 0, 0, "err_gen");
    clear_cnt();
    run_frame(MY, 11'd59, 0, 0, 0, 4'b0000, 1, 0, 0, "len59");
    clear_cnt();
    run_frame(MY, 11'd1515, 0, 0, 0, 4'b0000, 1, 0, 0, "len1515");
    run_frame(MY, 11'd60, 0, 0, 1, 4'b0001, 6, 1, 0, "len60");
    run_frame(MY, 11'd1514, 0, 0, 1, 4'b0001, 6, 0, 0, "len1514");
    run_frame(MY, 11'd59, 0, 1, 0, 4'b0000, 1, 0, 0, "err_len");
    promisc = 1'b1;
    run_frame(FGN, 11'd90, 0, 0, 1, 4'b1000, 6, 1, 0, "pro_fgn");
    run_frame(MC, 11'd90, 0, 0, 1, 4'b0100, 6, 1, 0, "pro_mc");
    run_frame(BC, 11'd90, 0, 0, 1, 4'b0010, 6, 1, 0, "pro_bc");
    run_frame(MY, 11'd90, 0, 0, 1, 4'b0001, 6, 1, 0, "pro_uni");
    promisc = 1'b0;
    run_frame(FGN, 11'd90, 0, 0, 0, 4'b0000, 6, 0, 0, "fgn_rej");
    reset_test();
    run_frame(MY, 11'd300, 0, 0, 1, 4'b0001, 6, 1, 1, "clr_ack");
    run_frame(MY, 11'd300, 0, 0, 1, 4'b0001, 6, 1, 0, "after_clr");
  endtask

  task automatic sat_seq();
    @(negedge clk);
    s_inc = 1'b1;
    repeat (65534) @(posedge clk);
    #1 chk("sat fffe", s_cnt, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1 chk("sat hold", s_cnt, 16'hFFFF);
    @(negedge clk);
    s_clr = 1'b1;
    @(posedge clk);
    #1 chk("sat clr prio", s_cnt, 0);
    @(negedge clk);
    s_clr = 1'b0;
    s_inc = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #2;
    clr_n   = 1'b0;
    s_rst_n = 1'b0;
    #10;
    chk("reset rxdone", rxdone, 0);
    chk("reset bufrd", bufrd, 0);
    chk("reset frmrdy", frmrdy, 0);
    chk("reset bufaddr", bufaddr, 0);
    chk("reset frmlen", frmlen, 0);
    chk("reset frmstat", frmstat, 0);
    chk("reset sat", s_cnt, 0);
    chk_cnts("reset");
    @(negedge clk);
    clr_n   = 1'b1;
    s_rst_n = 1'b1;
    fork
      main_seq();
      sat_seq();
    join
    repeat (2) @(negedge clk);
    chk("scoreboard empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
